// File: rtl/path_pkg.sv
// Shared definitions for path record handling: field layout, ordering codes,
// tracker modes and the tracker state encoding.
package path_pkg;

    localparam int PRESENT_BIT = 0;
    localparam int T_LSB       = 1;

    localparam logic [1:0] ORD_LT = 2'd0;
    localparam logic [1:0] ORD_EQ = 2'd1;
    localparam logic [1:0] ORD_GT = 2'd2;

    localparam int MODE_MIN = 0;
    localparam int MODE_MAX = 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HOLD,
        ST_EMIT
    } state_e;

    function automatic int h_lsb(input int cost_w);
        return 1 + cost_w;
    endfunction

    function automatic int tag_lsb(input int cost_w);
        return 1 + 2 * cost_w;
    endfunction

    function automatic int rec_w(input int cost_w, input int tag_w);
        return 1 + 2 * cost_w + tag_w;
    endfunction

endpackage

// File: rtl/path_order_cmp.sv
// Combinational path ordering: compares (sum, head) pairs lexicographically,
// unsigned, and returns ORD_LT / ORD_EQ / ORD_GT for a relative to b.
module path_order_cmp #(
    parameter int COST_W = 16,
    parameter int SUM_W  = 17
) (
    input  logic [SUM_W-1:0]  i_a_sum,
    input  logic [COST_W-1:0] i_a_h,
    input  logic [SUM_W-1:0]  i_b_sum,
    input  logic [COST_W-1:0] i_b_h,
    output logic [1:0]        o_ord
);
    import path_pkg::*;

    always_comb begin
        o_ord = ORD_EQ;
        if (i_a_sum < i_b_sum)
            o_ord = ORD_LT;
        else if (i_a_sum > i_b_sum)
            o_ord = ORD_GT;
        else if (i_a_h < i_b_h)
            o_ord = ORD_LT;
        else if (i_a_h > i_b_h)
            o_ord = ORD_GT;
    end

endmodule

// File: rtl/path_best_tracker.sv
// Streaming best-of-group tracker: registers each beat with its widened cost
// sum, keeps the best present record per group and emits it with the count.
module path_best_tracker #(
    parameter int COST_W = 16,
    parameter int TAG_W  = 32,
    parameter int CNT_W  = 16,
    parameter int MODE   = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [2*COST_W+TAG_W:0]     in_rec_i,
    input  logic                        in_last_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [2*COST_W+TAG_W:0]     out_rec_o,
    output logic [CNT_W-1:0]            out_cnt_o,
    output logic                        out_empty_o
);
    import path_pkg::*;

    localparam int REC_W = rec_w(COST_W, TAG_W);
    localparam int SUM_W = COST_W + 1;
    localparam int HL    = h_lsb(COST_W);

    logic               r_s1_vld;
    logic               r_s1_last;
    logic [REC_W-1:0]   r_s1_rec;
    logic [SUM_W-1:0]   r_s1_sum;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [REC_W-1:0]   r_best_rec;
    logic [REC_W-1:0]   w_best_rec_nxt;
    logic [SUM_W-1:0]   r_best_sum;
    logic [SUM_W-1:0]   w_best_sum_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic               w_in_fire;
    logic               w_s1_present;
    logic               w_better;
    logic [1:0]         w_ord;
    logic [COST_W-1:0]  w_in_h;
    logic [COST_W-1:0]  w_in_t;

    // A pending last beat in stage 1 blocks intake so at most one beat waits
    // behind a group boundary; the handshake cycle itself may take a new beat.
    assign in_ready_o = ~(r_s1_vld & r_s1_last) &
                        ((r_state != ST_EMIT) | out_ready_i);
    assign w_in_fire  = in_valid_i & in_ready_o;
    assign w_in_h     = in_rec_i[HL +: COST_W];
    assign w_in_t     = in_rec_i[T_LSB +: COST_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_rec  <= '0;
            r_s1_sum  <= '0;
        end else begin
            r_s1_vld <= w_in_fire;
            if (w_in_fire) begin
                r_s1_rec  <= in_rec_i;
                r_s1_last <= in_last_i;
                r_s1_sum  <= SUM_W'(w_in_h) + SUM_W'(w_in_t);
            end
        end
    end

    path_order_cmp #(
        .COST_W (COST_W),
        .SUM_W  (SUM_W)
    ) u_cmp (
        .i_a_sum (r_s1_sum),
        .i_a_h   (r_s1_rec[HL +: COST_W]),
        .i_b_sum (r_best_sum),
        .i_b_h   (r_best_rec[HL +: COST_W]),
        .o_ord   (w_ord)
    );

    // Strictly better only; equal keys leave the first arrival in place.
    assign w_better     = (MODE == MODE_MAX) ? (w_ord == ORD_GT) : (w_ord == ORD_LT);
    assign w_s1_present = r_s1_rec[PRESENT_BIT];
    assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_EMPTY;
            r_best_rec <= '0;
            r_best_sum <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_best_rec <= w_best_rec_nxt;
            r_best_sum <= w_best_sum_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_best_rec_nxt = r_best_rec;
        w_best_sum_nxt = r_best_sum;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            ST_EMPTY: begin
                if (r_s1_vld) begin
                    if (w_s1_present) begin
                        w_best_rec_nxt = r_s1_rec;
                        w_best_sum_nxt = r_s1_sum;
                        w_cnt_nxt      = CNT_W'(1);
                        w_state_nxt    = ST_HOLD;
                    end
                    if (r_s1_last)
                        w_state_nxt = ST_EMIT;
                end
            end
            ST_HOLD: begin
                if (r_s1_vld) begin
                    if (w_s1_present) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_better) begin
                            w_best_rec_nxt = r_s1_rec;
                            w_best_sum_nxt = r_s1_sum;
                        end
                    end
                    if (r_s1_last)
                        w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Clearing best here makes an empty group report a zero record.
                if (out_ready_i) begin
                    w_state_nxt    = ST_EMPTY;
                    w_best_rec_nxt = '0;
                    w_best_sum_nxt = '0;
                    w_cnt_nxt      = '0;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    assign out_valid_o = (r_state == ST_EMIT);
    assign out_rec_o   = r_best_rec;
    assign out_cnt_o   = r_cnt;
    assign out_empty_o = (r_state == ST_EMIT) && (r_cnt == '0);

endmodule

// File: tb/tb_path_best_tracker.sv
// Directed bench for path_best_tracker: MODE 0 and MODE 1 instances driven in
// lockstep from a group table, plus latency, backpressure and reset sequences.
module tb_path_best_tracker;
    localparam int CW = 16;
    localparam int TW = 32;
    localparam int NW = 16;
    localparam int RW = 1 + 2*CW + TW;

    typedef struct {
        logic [CW-1:0] h;
        logic [CW-1:0] t;
        logic [TW-1:0] tag;
        logic          pres;
        logic          last;
        logic [RW-1:0] exp0;
        logic [RW-1:0] exp1;
        logic [NW-1:0] cnt;
        logic          empty;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [RW-1:0] in_rec;
    logic          rdy0, rdy1, ov0, ov1, emp0, emp1;
    logic [RW-1:0] orec0, orec1;
    logic [NW-1:0] ocnt0, ocnt1;
    int            checks = 0;
    int            errors = 0;
    beat_t         tbl [14];

    always #5 clk = ~clk;

    path_best_tracker #(.COST_W(CW), .TAG_W(TW), .CNT_W(NW), .MODE(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .in_rec_i(in_rec), .in_last_i(in_last), .out_valid_o(ov0),
        .out_ready_i(out_ready), .out_rec_o(orec0), .out_cnt_o(ocnt0),
        .out_empty_o(emp0)
    );

    path_best_tracker #(.COST_W(CW), .TAG_W(TW), .CNT_W(NW), .MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_rec_i(in_rec), .in_last_i(in_last), .out_valid_o(ov1),
        .out_ready_i(out_ready), .out_rec_o(orec1), .out_cnt_o(ocnt1),
        .out_empty_o(emp1)
    );

    function automatic logic [RW-1:0] mk(input logic [CW-1:0] h, input logic [CW-1:0] t,
                                         input logic [TW-1:0] tag, input logic p);
        return {tag, h, t, p};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one beat at a negedge and returns at the negedge after it is taken.
    task automatic send(input logic [CW-1:0] h, input logic [CW-1:0] t,
                        input logic [TW-1:0] tag, input logic p, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_rec   = mk(h, t, tag, p);
        in_last  = last;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) chk("send_ready_timeout", rdy0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [RW-1:0] e0, input logic [RW-1:0] e1,
                              input logic [NW-1:0] cnt, input logic emp);
        int n = 0;
        while (!ov0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid0"}, ov0, 1);
        chk({name, "_valid1"}, ov1, 1);
        chk({name, "_rec0"}, orec0, e0);
        chk({name, "_cnt0"}, ocnt0, cnt);
        chk({name, "_empty0"}, emp0, emp);
        chk({name, "_rec1"}, orec1, e1);
        chk({name, "_cnt1"}, ocnt1, cnt);
        chk({name, "_empty1"}, emp1, emp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{16'd5, 16'd5, 32'h1, 1'b1, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[1]  = '{16'd3, 16'd4, 32'h2, 1'b1, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[2]  = '{16'd2, 16'd9, 32'h3, 1'b1, 1'b1, mk(16'd3, 16'd4, 32'h2, 1'b1),
                    mk(16'd2, 16'd9, 32'h3, 1'b1), 16'd3, 1'b0};
        tbl[3]  = '{16'd4, 16'd3, 32'hA, 1'b1, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[4]  = '{16'd4, 16'd3, 32'hB, 1'b1, 1'b1, mk(16'd4, 16'd3, 32'hA, 1'b1),
                    mk(16'd4, 16'd3, 32'hA, 1'b1), 16'd2, 1'b0};
        tbl[5]  = '{16'd6, 16'd1, 32'hC, 1'b1, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[6]  = '{16'd2, 16'd5, 32'hD, 1'b1, 1'b1, mk(16'd2, 16'd5, 32'hD, 1'b1),
                    mk(16'd6, 16'd1, 32'hC, 1'b1), 16'd2, 1'b0};
        tbl[7]  = '{16'hFFFF, 16'hFFFF, 32'h1, 1'b1, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[8]  = '{16'd1, 16'd0, 32'h2, 1'b1, 1'b1, mk(16'd1, 16'd0, 32'h2, 1'b1),
                    mk(16'hFFFF, 16'hFFFF, 32'h1, 1'b1), 16'd2, 1'b0};
        tbl[9]  = '{16'd3, 16'd3, 32'hE, 1'b0, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[10] = '{16'd1, 16'd1, 32'hF, 1'b0, 1'b1, '0, '0, 16'd0, 1'b1};
        tbl[11] = '{16'd2, 16'd2, 32'h10, 1'b0, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[12] = '{16'd7, 16'd7, 32'h11, 1'b1, 1'b0, '0, '0, 16'd0, 1'b0};
        tbl[13] = '{16'd0, 16'd0, 32'h12, 1'b0, 1'b1, mk(16'd7, 16'd7, 32'h11, 1'b1),
                    mk(16'd7, 16'd7, 32'h11, 1'b1), 16'd1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_rec = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", rdy0, 1);
        chk("rst_valid", ov0, 0);
        chk("rst_rec", orec0, 0);
        chk("rst_cnt", ocnt0, 0);
        chk("rst_empty", emp0, 0);

        for (int i = 0; i < 14; i++) begin
            send(tbl[i].h, tbl[i].t, tbl[i].tag, tbl[i].pres, tbl[i].last);
            if (tbl[i].last)
                get_result($sformatf("grp%0d", i), tbl[i].exp0, tbl[i].exp1,
                           tbl[i].cnt, tbl[i].empty);
        end

        // Single-beat group latency, then a held result under backpressure.
        send(16'd1, 16'd1, 32'h77, 1'b1, 1'b1);
        chk("lat_valid_early", ov0, 0);
        chk("lat_ready_blocked", rdy0, 0);
        @(negedge clk);
        chk("lat_valid_2cyc", ov0, 1);
        in_valid = 1'b1;
        in_rec   = mk(16'd8, 16'd8, 32'h55, 1'b1);
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_ready0_%0d", k), rdy0, 0);
            chk($sformatf("bp_ready1_%0d", k), rdy1, 0);
            chk($sformatf("bp_valid_%0d", k), ov0, 1);
            chk($sformatf("bp_rec_%0d", k), orec0, mk(16'd1, 16'd1, 32'h77, 1'b1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_on_handshake", rdy0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_valid_dropped", ov0, 0);
        @(negedge clk);
        chk("bp_next_valid", ov0, 1);
        get_result("bp_next", mk(16'd8, 16'd8, 32'h55, 1'b1), mk(16'd8, 16'd8, 32'h55, 1'b1),
                   16'd1, 1'b0);

        // Reset in the middle of a group discards the partial group.
        send(16'd1, 16'd2, 32'h21, 1'b1, 1'b0);
        send(16'd3, 16'd4, 32'h22, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ready", rdy0, 1);
        chk("mrst_cnt", ocnt0, 0);
        chk("mrst_rec", orec0, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mrst_valid_%0d", k), ov0, 0);
            @(negedge clk);
        end
        send(16'd9, 16'd0, 32'h99, 1'b1, 1'b1);
        chk("mrst_lat_early", ov0, 0);
        @(negedge clk);
        chk("mrst_lat_2cyc", ov0, 1);
        get_result("mrst_grp", mk(16'd9, 16'd0, 32'h99, 1'b1), mk(16'd9, 16'd0, 32'h99, 1'b1),
                   16'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
